// File: rtl/mux_arb_ctrl.sv
// mux_arb_ctrl
//   Arbitrates two valid/ready requesters onto one registered output word.
//   A combinational round-robin winner drives a 2:1 data mux, and the
//   selected word is captured into out_data on accept. A two-state FSM
//   (IDLE / HOLD) tracks whether out_data holds an unconsumed word.
//
// Handshake: a word moves whenever valid and ready are both 1 at a rising
//   clk edge. For requesters, ready is combinational (zero-cycle latency).
//   For the output side, out_valid is registered.
//
// Parameters
//   WIDTH        data width of each requester and of out_data
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   req0_valid   requester 0 offers req0_data
//   req0_data    requester 0 payload (mux d0)
//   req0_ready   requester 0 word accepted this cycle
//   req1_valid   requester 1 offers req1_data
//   req1_data    requester 1 payload (mux d1)
//   req1_ready   requester 1 word accepted this cycle
//   out_valid    out_data holds a valid word (FSM is in HOLD)
//   out_data     registered mux output
//   out_ready    downstream consumes out_data when out_valid=1
//   out_src      requester index of the word in out_data
//   sel          mux select driven this cycle (1 = requester 1)
//   xfer_count   number of accepted words, wraps at 16 bits
//
// Build option
//   MUX_ARB_REV_GATE_EN  when defined, the winner logic and the per-bit data
//                        mux are built from Toffoli-based reversible cells.
//                        Port behaviour is identical in both builds.

`ifdef MUX_ARB_REV_GATE_EN
// Toffoli cell: the controls pass through unchanged, so only the target is
// modelled.
module mux_arb_toffoli (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic t
);
   assign t = c ^ (a & b);
endmodule

// NOT uses controls tied to 1.
module mux_arb_rev_not (
   input  logic a,
   output logic y
);
   mux_arb_toffoli u_t (.a(1'b1), .b(1'b1), .c(a), .t(y));
endmodule

// AND uses a target ancilla tied to 0.
module mux_arb_rev_and (
   input  logic a,
   input  logic b,
   output logic y
);
   mux_arb_toffoli u_t (.a(a), .b(b), .c(1'b0), .t(y));
endmodule

// OR is built by De Morgan: ~(~a & ~b).
module mux_arb_rev_or (
   input  logic a,
   input  logic b,
   output logic y
);
   logic na, nb, nab;
   mux_arb_rev_not u_na (.a(a), .y(na));
   mux_arb_rev_not u_nb (.a(b), .y(nb));
   mux_arb_rev_and u_an (.a(na), .b(nb), .y(nab));
   mux_arb_rev_not u_y  (.a(nab), .y(y));
endmodule

// 2:1 mux: y = (s & d1) | (~s & d0).
module mux_arb_rev_mux2 (
   input  logic s,
   input  logic d0,
   input  logic d1,
   output logic y
);
   logic ns, p0, p1;
   mux_arb_rev_not u_ns (.a(s), .y(ns));
   mux_arb_rev_and u_p0 (.a(ns), .b(d0), .y(p0));
   mux_arb_rev_and u_p1 (.a(s), .b(d1), .y(p1));
   mux_arb_rev_or  u_y  (.a(p0), .b(p1), .y(y));
endmodule
`endif

module mux_arb_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   input  logic [WIDTH-1:0] req0_data,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [WIDTH-1:0] req1_data,
   output logic             req1_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic             out_src,
   output logic             sel,
   output logic [15:0]      xfer_count
);

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t           state;
   state_t           state_next;
   logic             last_grant;
   logic             sel_q;
   logic             has_win;
   logic             win_idx;
   logic             load_ok;
   logic             accept;
   logic [WIDTH-1:0] mux_data;

`ifdef MUX_ARB_REV_GATE_EN
   logic both, n_lg, n_both, tie_pick, solo_pick;

   mux_arb_rev_and u_both  (.a(req0_valid), .b(req1_valid), .y(both));
   mux_arb_rev_not u_nlg   (.a(last_grant), .y(n_lg));
   mux_arb_rev_not u_nboth (.a(both), .y(n_both));
   mux_arb_rev_and u_tie   (.a(both), .b(n_lg), .y(tie_pick));
   mux_arb_rev_and u_solo  (.a(n_both), .b(req1_valid), .y(solo_pick));
   mux_arb_rev_or  u_win   (.a(tie_pick), .b(solo_pick), .y(win_idx));
   mux_arb_rev_or  u_has   (.a(req0_valid), .b(req1_valid), .y(has_win));

   for (genvar i = 0; i < WIDTH; i++) begin : g_mux
      mux_arb_rev_mux2 u_mux (
         .s (sel),
         .d0(req0_data[i]),
         .d1(req1_data[i]),
         .y (mux_data[i])
      );
   end
`else
   // On a tie the requester not granted last wins; otherwise the single
   // valid requester wins.
   assign has_win  = req0_valid | req1_valid;
   assign win_idx  = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
   assign mux_data = sel ? req1_data : req0_data;
`endif

   assign load_ok = (state == IDLE) || out_ready;

   // Gating with rst_n keeps readies and sel at 0 while reset is held,
   // even though requests may still be asserted.
   assign accept     = rst_n & load_ok & has_win;
   assign sel        = rst_n & (has_win ? win_idx : sel_q);
   assign req0_ready = accept & ~win_idx;
   assign req1_ready = accept & win_idx;
   assign out_valid  = (state == HOLD);

   always_comb begin
      state_next = state;
      if (accept) begin
         state_next = HOLD;
      end else if ((state == HOLD) && out_ready) begin
         state_next = IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         out_data   <= '0;
         out_src    <= 1'b0;
         sel_q      <= 1'b0;
         last_grant <= 1'b1;
         xfer_count <= 16'h0000;
      end else begin
         state <= state_next;
         sel_q <= sel;
         if (accept) begin
            out_data   <= mux_data;
            out_src    <= sel;
            last_grant <= sel;
            xfer_count <= xfer_count + 16'h0001;
         end
      end
   end

endmodule

// File: tb/tb_mux_arb_ctrl.sv
// Bench for mux_arb_ctrl. A reference model predicts readies, sel and the
// FSM state for each cycle. Every accepted word is pushed as {src, data} to
// exp_q and compared against out_data/out_src while it is presented.
module tb_mux_arb_ctrl;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         req0_valid;
   logic [W-1:0] req0_data;
   logic         req0_ready;
   logic         req1_valid;
   logic [W-1:0] req1_data;
   logic         req1_ready;
   logic         out_valid;
   logic [W-1:0] out_data;
   logic         out_ready;
   logic         out_src;
   logic         sel;
   logic [15:0]  xfer_count;

   mux_arb_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req0_valid(req0_valid),
      .req0_data (req0_data),
      .req0_ready(req0_ready),
      .req1_valid(req1_valid),
      .req1_data (req1_data),
      .req1_ready(req1_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .out_src   (out_src),
      .sel       (sel),
      .xfer_count(xfer_count)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // scoreboard and model state
   logic [W:0]  exp_q[$];
   logic [W:0]  m_last;
   logic        m_state;
   logic        m_lg;
   logic        m_sel;
   logic [15:0] m_count;
   logic        chk_en;
   int          checks;
   int          failures;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = 1'b0;
      m_lg    = 1'b1;
      m_sel   = 1'b0;
      m_count = 16'h0000;
      m_last  = '0;
      exp_q.delete();
   endtask

   // Assert reset asynchronously, check forced outputs before any clk edge,
   // then release just after a rising edge.
   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_src", 32'(out_src), 32'd0);
      check("rst_sel", 32'(sel), 32'd0);
      check("rst_req0_ready", 32'(req0_ready), 32'd0);
      check("rst_req1_ready", 32'(req1_ready), 32'd0);
      check("rst_xfer_count", 32'(xfer_count), 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // One clock cycle: compare at the falling edge, advance the model at the
   // rising edge. Inputs must be stable before the call.
   task automatic step();
      logic has, wi, lok, e_r0, e_r1, e_sel;
      logic [W:0] tmp;
      @(negedge clk);
      has   = req0_valid | req1_valid;
      wi    = (req0_valid & req1_valid) ? ~m_lg : req1_valid;
      lok   = ~m_state | out_ready;
      e_r0  = lok & has & ~wi;
      e_r1  = lok & has & wi;
      e_sel = has ? wi : m_sel;
      if (chk_en) begin
         check("req0_ready", 32'(req0_ready), 32'(e_r0));
         check("req1_ready", 32'(req1_ready), 32'(e_r1));
         check("sel", 32'(sel), 32'(e_sel));
         check("out_valid", 32'(out_valid), 32'(m_state));
         check("xfer_count", 32'(xfer_count), 32'(m_count));
      end
      if (m_state) begin
         if (chk_en) begin
            check("exp_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               check("out_data", 32'(out_data), 32'(exp_q[0][W-1:0]));
               check("out_src", 32'(out_src), 32'(exp_q[0][W]));
            end
         end
         if (out_ready && exp_q.size() != 0) tmp = exp_q.pop_front();
      end else if (chk_en) begin
         check("idle_out_data", 32'(out_data), 32'(m_last[W-1:0]));
         check("idle_out_src", 32'(out_src), 32'(m_last[W]));
      end
      @(posedge clk);
      m_sel = e_sel;
      if (lok && has) begin
         tmp = {wi, wi ? req1_data : req0_data};
         exp_q.push_back(tmp);
         m_last  = tmp;
         m_lg    = wi;
         m_state = 1'b1;
         m_count = m_count + 16'h0001;
      end else if (m_state && out_ready) begin
         m_state = 1'b0;
      end
      #1;
   endtask

   task automatic drive(input logic v0, input logic [W-1:0] d0,
                        input logic v1, input logic [W-1:0] d1,
                        input logic ordy);
      req0_valid = v0;
      req0_data  = d0;
      req1_valid = v1;
      req1_data  = d1;
      out_ready  = ordy;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      chk_en   = 1'b1;
      rst_n    = 1'b0;
      drive(1'b1, 8'hA5, 1'b0, 8'h00, 1'b1);
      do_reset();

      // single requester: ready in the same cycle, word one cycle later
      step();
      check("a5_count_after_accept", 32'(xfer_count), 32'd1);
      check("a5_out_data_direct", 32'(out_data), 32'hA5);
      drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      step();
      step();
      step();

      // tie from reset: grants alternate starting with requester 0
      drive(1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
      do_reset();
      for (int i = 0; i < 4; i++) step();
      check("alt_out_data_4th", 32'(out_data), 32'h22);

      // back-pressure while both requesters stay valid
      drive(1'b1, 8'h11, 1'b1, 8'h22, 1'b0);
      for (int i = 0; i < 5; i++) step();
      check("stall_xfer_count", 32'(xfer_count), 32'(m_count));
      drive(1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
      step();
      step();
      drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      step();
      step();

      // random traffic
      for (int i = 0; i < 300; i++) begin
         drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
               1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
               1'($urandom_range(0, 3) != 0));
         step();
      end

      // counter wrap: 65535 accepts, then one more
      drive(1'b1, 8'h5A, 1'b0, 8'h00, 1'b1);
      do_reset();
      chk_en = 1'b0;
      for (int i = 0; i < 65535; i++) step();
      chk_en = 1'b1;
      check("count_ffff", 32'(xfer_count), 32'hFFFF);
      step();
      check("count_wrap", 32'(xfer_count), 32'h0000);
      drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      step();
      step();

      // asynchronous reset while holding 0x3C
      drive(1'b1, 8'h3C, 1'b0, 8'h00, 1'b0);
      step();
      check("pre_rst_out_data", 32'(out_data), 32'h3C);
      check("pre_rst_out_valid", 32'(out_valid), 32'd1);
      drive(1'b1, 8'h11, 1'b1, 8'h22, 1'b0);
      do_reset();
      drive(1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
      step();
      check("post_rst_first_src", 32'(out_src), 32'd0);
      check("post_rst_first_data", 32'(out_data), 32'h11);
      step();
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
